// File: rtl/mem_resp_merge_pkg.sv
// Shared definitions for the bank response merge block.
// Payload layout (LSB first): dest, src, is_flush, operation, data, addr.
package mem_resp_merge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned ID_W   = 2;

  localparam int unsigned DEST_LSB  = 0;
  localparam int unsigned SRC_LSB   = DEST_LSB + ID_W;
  localparam int unsigned FLUSH_LSB = SRC_LSB + ID_W;
  localparam int unsigned OP_LSB    = FLUSH_LSB + 1;
  localparam int unsigned DATA_LSB  = OP_LSB + OP_W;

  // Total packed payload width for a given cache-line size.
  function automatic int unsigned payload_w(input int unsigned cl_size);
    return ADDR_W + cl_size + OP_W + 1 + 2 * ID_W;
  endfunction

endpackage

// File: rtl/mem_resp_merge_if.sv
// Bus bundle for mem_resp_merge: even/odd bank response inputs with their
// backpressure, the merged response output, consumer backpressure and the
// sticky overflow flag. slave = merge block side, master = bank/consumer side.
interface mem_resp_merge_if
  import mem_resp_merge_pkg::*;
#(
  parameter int unsigned CL_SIZE = 128
) ();

  logic [ADDR_W-1:0]  addr_in_even;
  logic [CL_SIZE-1:0] data_in_even;
  logic [OP_W-1:0]    operation_in_even;
  logic               is_flush_in_even;
  logic               alloc_in_even;
  logic [ID_W-1:0]    src_in_even;
  logic [ID_W-1:0]    dest_in_even;
  logic               full_out_even;

  logic [ADDR_W-1:0]  addr_in_odd;
  logic [CL_SIZE-1:0] data_in_odd;
  logic [OP_W-1:0]    operation_in_odd;
  logic               is_flush_in_odd;
  logic               alloc_in_odd;
  logic [ID_W-1:0]    src_in_odd;
  logic [ID_W-1:0]    dest_in_odd;
  logic               full_out_odd;

  logic [ADDR_W-1:0]  addr_out;
  logic [CL_SIZE-1:0] data_out;
  logic [OP_W-1:0]    operation_out;
  logic               is_flush_out;
  logic               alloc_out;
  logic [ID_W-1:0]    src_out;
  logic [ID_W-1:0]    dest_out;
  logic               bank_out;
  logic               full_in;
  logic               overflow_err;

  modport slave (
    input  addr_in_even, data_in_even, operation_in_even, is_flush_in_even,
           alloc_in_even, src_in_even, dest_in_even,
    input  addr_in_odd, data_in_odd, operation_in_odd, is_flush_in_odd,
           alloc_in_odd, src_in_odd, dest_in_odd,
    input  full_in,
    output full_out_even, full_out_odd,
    output addr_out, data_out, operation_out, is_flush_out, alloc_out,
           src_out, dest_out, bank_out, overflow_err
  );

  modport master (
    output addr_in_even, data_in_even, operation_in_even, is_flush_in_even,
           alloc_in_even, src_in_even, dest_in_even,
    output addr_in_odd, data_in_odd, operation_in_odd, is_flush_in_odd,
           alloc_in_odd, src_in_odd, dest_in_odd,
    output full_in,
    input  full_out_even, full_out_odd,
    input  addr_out, data_out, operation_out, is_flush_out, alloc_out,
           src_out, dest_out, bank_out, overflow_err
  );

endinterface

// File: rtl/mem_resp_merge_resp_fifo.sv
// Per-bank response FIFO.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/wdata_i write;
// pop_i pop of the head (only honoured when non-empty); rdata_o head entry;
// count_o occupancy; full_o registered (count >= Depth-1, one slot of slack);
// overflow_o sticky, set when a push arrives with no room.
module mem_resp_merge_resp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, overflow_q;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  // A same-edge pop frees a slot, so a push at count == Depth is still taken.
  assign push_ok = push_i && ((count_q < CntW'(Depth)) || pop_ok);
  assign count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      full_q     <= (count_d >= CntW'(Depth - 1));
      overflow_q <= overflow_q | (push_i & ~push_ok);
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o    = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/mem_resp_merge.sv
// Merges the even and odd DRAM bank response streams into one response stream
// for the cache fill path. Each bank feeds its own FIFO; a round-robin arbiter
// picks a non-empty FIFO each cycle the consumer is not full and registers the
// head entry onto the output with a one-cycle alloc_out pulse.
// Ports: clk, rst (async active-low); bus (slave modport) carries both bank
// inputs with full_out_even/odd, the merged output with bank_out, full_in
// from the consumer and the sticky overflow_err.
module mem_resp_merge
  import mem_resp_merge_pkg::*;
#(
  parameter int unsigned CL_SIZE = 128,
  parameter int unsigned DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_resp_merge_if.slave  bus
);

  localparam int unsigned PayloadW = payload_w(CL_SIZE);
  localparam int unsigned CntW     = $clog2(DEPTH + 1);

  logic [PayloadW-1:0] wdata_even, wdata_odd, rdata_even, rdata_odd, head;
  logic [CntW-1:0]     count_even, count_odd;
  logic                ovf_even, ovf_odd;
  logic                grant_even, grant_odd;

  logic [PayloadW-1:0] payload_q;
  logic                alloc_q, bank_q;
  logic                rr_q;  // side granted last: 0 = even, 1 = odd

  assign wdata_even = {bus.addr_in_even, bus.data_in_even, bus.operation_in_even,
                       bus.is_flush_in_even, bus.src_in_even, bus.dest_in_even};
  assign wdata_odd  = {bus.addr_in_odd, bus.data_in_odd, bus.operation_in_odd,
                       bus.is_flush_in_odd, bus.src_in_odd, bus.dest_in_odd};

  mem_resp_merge_resp_fifo #(
    .Depth (DEPTH),
    .Width (PayloadW)
  ) u_fifo_even (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (bus.alloc_in_even),
    .wdata_i    (wdata_even),
    .pop_i      (grant_even),
    .rdata_o    (rdata_even),
    .count_o    (count_even),
    .full_o     (bus.full_out_even),
    .overflow_o (ovf_even)
  );

  mem_resp_merge_resp_fifo #(
    .Depth (DEPTH),
    .Width (PayloadW)
  ) u_fifo_odd (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (bus.alloc_in_odd),
    .wdata_i    (wdata_odd),
    .pop_i      (grant_odd),
    .rdata_o    (rdata_odd),
    .count_o    (count_odd),
    .full_o     (bus.full_out_odd),
    .overflow_o (ovf_odd)
  );

  // Under contention the side opposite the last grant wins.
  always_comb begin
    grant_even = 1'b0;
    grant_odd  = 1'b0;
    if (!bus.full_in) begin
      if ((count_even != '0) && (count_odd != '0)) begin
        grant_even = rr_q;
        grant_odd  = ~rr_q;
      end else begin
        grant_even = (count_even != '0);
        grant_odd  = (count_odd != '0);
      end
    end
  end

  assign head = grant_odd ? rdata_odd : rdata_even;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      payload_q <= '0;
      alloc_q   <= 1'b0;
      bank_q    <= 1'b0;
      rr_q      <= 1'b1;  // odd, so even wins the first contention
    end else begin
      alloc_q <= grant_even | grant_odd;
      if (grant_even | grant_odd) begin
        payload_q <= head;
        bank_q    <= grant_odd;
        rr_q      <= grant_odd;
      end
    end
  end

  assign bus.addr_out      = payload_q[PayloadW-1 -: ADDR_W];
  assign bus.data_out      = payload_q[DATA_LSB +: CL_SIZE];
  assign bus.operation_out = payload_q[OP_LSB +: OP_W];
  assign bus.is_flush_out  = payload_q[FLUSH_LSB];
  assign bus.src_out       = payload_q[SRC_LSB +: ID_W];
  assign bus.dest_out      = payload_q[DEST_LSB +: ID_W];
  assign bus.alloc_out     = alloc_q;
  assign bus.bank_out      = bank_q;
  assign bus.overflow_err  = ovf_even | ovf_odd;

endmodule

// File: tb/tb_mem_resp_merge.sv
module tb_mem_resp_merge;

  localparam int unsigned CL    = 128;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0]   addr;
    logic [CL-1:0] data;
    logic [2:0]    op;
    logic          fl;
    logic [1:0]    src;
    logic [1:0]    dest;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_resp_merge_if #(.CL_SIZE(CL)) bus ();

  mem_resp_merge #(
    .CL_SIZE (CL),
    .DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t        exp_e[$];
  ent_t        exp_o[$];
  int unsigned seen_bank[$];
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;

  function automatic ent_t mk(input logic [31:0] a, input logic [1:0] d);
    ent_t e;
    e.addr = a;
    e.data = {16{8'hA5}} ^ {{(CL - 32){1'b0}}, a};
    e.op   = a[6:4];
    e.fl   = a[3];
    e.src  = ~a[5:4];
    e.dest = d;
    return e;
  endfunction

  // Scoreboard: every delivered pulse is matched against its side's queue.
  always @(negedge clk) begin : monitor
    ent_t got, want;
    if (rst === 1'b1 && bus.alloc_out === 1'b1) begin
      pulses++;
      seen_bank.push_back(int'(bus.bank_out));
      got.addr = bus.addr_out;
      got.data = bus.data_out;
      got.op   = bus.operation_out;
      got.fl   = bus.is_flush_out;
      got.src  = bus.src_out;
      got.dest = bus.dest_out;
      checks++;
      if (bus.bank_out === 1'b0 && exp_e.size() > 0) begin
        want = exp_e.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL payload_even: got %h expected %h", got, want);
        end
      end else if (bus.bank_out === 1'b1 && exp_o.size() > 0) begin
        want = exp_o.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL payload_odd: got %h expected %h", got, want);
        end
      end else begin
        errors++;
        $display("FAIL unexpected_pulse: got bank %b addr %h expected no pulse",
                 bus.bank_out, bus.addr_out);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.full_in = 1'b0;
    bus.alloc_in_even = 1'b0;
    bus.alloc_in_odd  = 1'b0;
    bus.addr_in_even = '0; bus.data_in_even = '0; bus.operation_in_even = '0;
    bus.is_flush_in_even = 1'b0; bus.src_in_even = '0; bus.dest_in_even = '0;
    bus.addr_in_odd = '0; bus.data_in_odd = '0; bus.operation_in_odd = '0;
    bus.is_flush_in_odd = 1'b0; bus.src_in_odd = '0; bus.dest_in_odd = '0;
    exp_e.delete();
    exp_o.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Drives one cycle of bank traffic; returns 1 time unit after the edge.
  task automatic push(input bit pe, input logic [31:0] ae, input logic [1:0] de,
                      input bit po, input logic [31:0] ao, input logic [1:0] dox,
                      input bit keep_e);
    ent_t e, o;
    e = mk(ae, de);
    o = mk(ao, dox);
    bus.alloc_in_even = pe;
    bus.addr_in_even = e.addr; bus.data_in_even = e.data; bus.operation_in_even = e.op;
    bus.is_flush_in_even = e.fl; bus.src_in_even = e.src; bus.dest_in_even = e.dest;
    bus.alloc_in_odd = po;
    bus.addr_in_odd = o.addr; bus.data_in_odd = o.data; bus.operation_in_odd = o.op;
    bus.is_flush_in_odd = o.fl; bus.src_in_odd = o.src; bus.dest_in_odd = o.dest;
    if (pe && keep_e) exp_e.push_back(e);
    if (po) exp_o.push_back(o);
    @(posedge clk);
    #1;
    bus.alloc_in_even = 1'b0;
    bus.alloc_in_odd  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_e.size() != 0 || exp_o.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_e.size() != 0 || exp_o.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d entries pending expected 0/0",
               exp_e.size(), exp_o.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.alloc_out, bus.addr_out, bus.data_out, bus.operation_out, bus.is_flush_out,
           bus.src_out, bus.dest_out, bus.bank_out, bus.full_out_even, bus.full_out_odd,
           bus.overflow_err} !== '0) begin
        errors++;
        $display("FAIL reset_idle: got alloc %b addr %h full %b%b ovf %b expected all 0",
                 bus.alloc_out, bus.addr_out, bus.full_out_even, bus.full_out_odd,
                 bus.overflow_err);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int p0 = pulses;
    push(1'b1, 32'h40, 2'd2, 1'b0, 32'h0, 2'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.alloc_out !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got alloc_out %b expected 0", bus.alloc_out);
    end
    @(negedge clk);
    checks++;
    if ({bus.alloc_out, bus.addr_out, bus.dest_out, bus.bank_out} !==
        {1'b1, 32'h40, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL single_latency: got alloc %b addr %h dest %0d bank %b expected 1 40 2 0",
               bus.alloc_out, bus.addr_out, bus.dest_out, bus.bank_out);
    end
    @(posedge clk);
    #1;
    idle(4);
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL single_pulse_count: got %0d expected 1", pulses - p0);
    end
  endtask

  task automatic test_both();
    do_reset();
    seen_bank.delete();
    for (int i = 0; i < 3; i++)
      push(1'b1, 32'h100 + 32'(i * 16), 2'(i), 1'b1, 32'h200 + 32'(i * 16), 2'(i), 1'b1);
    wait_drain(20);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (seen_bank.size() <= i || seen_bank[i] != 32'(i % 2)) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d expected %0d", i,
                 (seen_bank.size() > i) ? int'(seen_bank[i]) : -1, i % 2);
      end
    end
  endtask

  task automatic test_full();
    int p0 = pulses;
    bus.full_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 32'h300 + 32'(i * 16), 2'(i), 1'b0, 32'h0, 2'd0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.full_out_even !== (i == 2)) begin
        errors++;
        $display("FAIL full_out_even[%0d]: got %b expected %b", i, bus.full_out_even, i == 2);
      end
      @(posedge clk);
      #1;
    end
    idle(3);
    checks++;
    if (pulses != p0) begin
      errors++;
      $display("FAIL backpressure_hold: got %0d pulses expected 0", pulses - p0);
    end
    bus.full_in = 1'b0;
    wait_drain(20);
    idle(2);
    checks++;
    if (pulses - p0 != 3 || bus.full_out_even !== 1'b0) begin
      errors++;
      $display("FAIL full_release: got %0d pulses full %b expected 3 pulses full 0",
               pulses - p0, bus.full_out_even);
    end
  endtask

  task automatic test_overflow();
    int p0 = pulses;
    bus.full_in = 1'b1;
    for (int i = 0; i < 5; i++)
      push(1'b1, 32'h400 + 32'(i * 16), 2'(i), 1'b0, 32'h0, 2'd0, i < 4);
    @(negedge clk);
    checks++;
    if ({bus.overflow_err, bus.full_out_even} !== 2'b11) begin
      errors++;
      $display("FAIL overflow_set: got ovf %b full %b expected 1 1",
               bus.overflow_err, bus.full_out_even);
    end
    @(posedge clk);
    #1;
    bus.full_in = 1'b0;
    wait_drain(20);
    idle(3);
    checks++;
    if (pulses - p0 != 4) begin
      errors++;
      $display("FAIL overflow_count: got %0d pulses expected 4", pulses - p0);
    end
    checks++;
    if (bus.overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b expected 1", bus.overflow_err);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    bus.full_in = 1'b1;
    push(1'b1, 32'h600, 2'd1, 1'b0, 32'h0, 2'd0, 1'b1);
    push(1'b1, 32'h610, 2'd3, 1'b0, 32'h0, 2'd0, 1'b1);
    bus.full_in = 1'b0;
    @(posedge clk);
    #7;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.alloc_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got alloc_out %b expected 0", bus.alloc_out);
    end
    exp_e.delete();
    exp_o.delete();
    p0 = pulses;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(10);
    checks++;
    if (pulses != p0 ||
        {bus.full_out_even, bus.full_out_odd, bus.overflow_err, bus.alloc_out} !== 4'b0) begin
      errors++;
      $display("FAIL reset_discard: got %0d pulses full %b%b ovf %b expected 0 pulses all 0",
               pulses - p0, bus.full_out_even, bus.full_out_odd, bus.overflow_err);
    end
    // A stale entry left in the FIFO would surface ahead of this one.
    push(1'b1, 32'h700, 2'd1, 1'b0, 32'h0, 2'd0, 1'b1);
    wait_drain(20);
    idle(3);
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL reset_empty: got %0d pulses expected 1", pulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_full();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
